// File: rtl/coder_dec_pkg.sv
// Shared MLT-3 symbol definitions for the encoder/decoder pair.
package coder_dec_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t ZERO    = 2'b00;
  localparam sym_t POS     = 2'b01;
  localparam sym_t NEG     = 2'b11;
  localparam sym_t ILLEGAL = 2'b10;

endpackage

// File: rtl/coder_dec_coder.sv
// MLT-3 encoder: a 1 steps the line through 0, +1, 0, -1; a 0 holds the level.
module coder
  import coder_dec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic [1:0] mlt_out
);

  sym_t level_q, level_d;
  sym_t last_nz_q, last_nz_d;

  always_comb begin
    level_d   = level_q;
    last_nz_d = last_nz_q;
    if (data_in) begin
      if (level_q == ZERO) begin
        // Leaving zero always goes to the sign opposite the last excursion.
        level_d   = (last_nz_q == POS) ? NEG : POS;
        last_nz_d = level_d;
      end else begin
        level_d = ZERO;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= ZERO;
      last_nz_q <= NEG;
    end else begin
      level_q   <= level_d;
      last_nz_q <= last_nz_d;
    end
  end

  assign mlt_out = level_q;

endmodule

// File: rtl/coder_dec_dec.sv
// MLT-3 decoder: a symbol change decodes as 1; flags illegal or out-of-order symbols.
module dec
  import coder_dec_pkg::*;
#(
  parameter bit CHECK_ORDER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] line_in,
  output logic       data_out,
  output logic       error
);

  sym_t prev_q, prev_d;
  sym_t last_nz_q, last_nz_d;
  logic data_d, error_d;
  logic data_q, error_q;
  logic is_illegal, is_cross, is_order;

  always_comb begin
    is_illegal = (line_in == ILLEGAL);
    is_cross   = ((prev_q == POS) && (line_in == NEG)) ||
                 ((prev_q == NEG) && (line_in == POS));
    is_order   = CHECK_ORDER && (prev_q == ZERO) && (line_in != ZERO) &&
                 (line_in == last_nz_q);
    error_d    = is_illegal | is_cross | is_order;
    data_d     = !error_d && (line_in != prev_q);

    prev_d    = prev_q;
    last_nz_d = last_nz_q;
    // An illegal symbol carries no level, so history is kept; other errors resync.
    if (!is_illegal) begin
      prev_d = line_in;
      if (line_in != ZERO) last_nz_d = line_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= ZERO;
      last_nz_q <= NEG;
      data_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      last_nz_q <= last_nz_d;
      data_q    <= data_d;
      error_q   <= error_d;
    end
  end

  assign data_out = data_q;
  assign error    = error_q;

endmodule

// File: rtl/coder_dec.sv
// MLT-3 encoder and decoder side by side; loop mlt_out to line_in externally for loopback.
module coder_dec #(
  parameter bit CHECK_ORDER = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic [1:0] mlt_out,
  input  logic [1:0] line_in,
  output logic       data_out,
  output logic       error
);

  coder u_coder (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .mlt_out (mlt_out)
  );

  dec #(
    .CHECK_ORDER (CHECK_ORDER)
  ) u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (line_in),
    .data_out (data_out),
    .error    (error)
  );

endmodule

// File: tb/tb_coder_dec.sv
// Directed bench for coder_dec: encoder table, decoder table, loopback and reset sequences.
module tb_coder_dec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_in;
  logic       loop;
  logic [1:0] line_drv;
  logic [1:0] line_in;
  logic [1:0] mlt_out, mlt_out_b;
  logic       data_out, error, data_out_b, error_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign line_in = loop ? mlt_out : line_drv;

  coder_dec #(.CHECK_ORDER(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .mlt_out  (mlt_out),
    .line_in  (line_in),
    .data_out (data_out),
    .error    (error)
  );

  coder_dec #(.CHECK_ORDER(1'b0)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .mlt_out  (mlt_out_b),
    .line_in  (line_in),
    .data_out (data_out_b),
    .error    (error_b)
  );

  typedef struct {
    logic       din;
    logic [1:0] mlt;
  } enc_vec_t;

  typedef struct {
    logic [1:0] line;
    logic       dout;
    logic       err;
    logic       dout_b;
    logic       err_b;
  } dec_vec_t;

  enc_vec_t enc[10];
  dec_vec_t dtab[14];
  logic     lb_stream[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    data_in  = 1'b0;
    line_drv = 2'b00;
    loop     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    enc[0] = '{1'b1, 2'b01};
    enc[1] = '{1'b1, 2'b00};
    enc[2] = '{1'b1, 2'b11};
    enc[3] = '{1'b1, 2'b00};
    enc[4] = '{1'b0, 2'b00};
    enc[5] = '{1'b1, 2'b01};
    enc[6] = '{1'b0, 2'b01};
    enc[7] = '{1'b0, 2'b01};
    enc[8] = '{1'b1, 2'b00};
    enc[9] = '{1'b1, 2'b11};

    //            line   d  e  db eb
    dtab[0]  = '{2'b00, 0, 0, 0, 0};
    dtab[1]  = '{2'b10, 0, 1, 0, 1};
    dtab[2]  = '{2'b00, 0, 0, 0, 0};
    dtab[3]  = '{2'b01, 1, 0, 1, 0};
    dtab[4]  = '{2'b11, 0, 1, 0, 1};
    dtab[5]  = '{2'b00, 1, 0, 1, 0};
    dtab[6]  = '{2'b01, 1, 0, 1, 0};
    dtab[7]  = '{2'b00, 1, 0, 1, 0};
    dtab[8]  = '{2'b01, 0, 1, 1, 0};
    dtab[9]  = '{2'b01, 0, 0, 0, 0};
    dtab[10] = '{2'b01, 0, 0, 0, 0};
    dtab[11] = '{2'b10, 0, 1, 0, 1};
    dtab[12] = '{2'b01, 0, 0, 0, 0};
    dtab[13] = '{2'b00, 1, 0, 1, 0};

    lb_stream = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state, observed while reset is held.
    rst_n    = 1'b0;
    data_in  = 1'b1;
    line_drv = 2'b01;
    loop     = 1'b0;
    #12;
    check("reset_mlt_out", int'(mlt_out), 0);
    check("reset_data_out", int'(data_out), 0);
    check("reset_error", int'(error), 0);

    // Encoder table from reset.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      data_in = enc[i].din;
      step();
      check($sformatf("enc[%0d]", i), int'(mlt_out), int'(enc[i].mlt));
      check($sformatf("enc_b[%0d]", i), int'(mlt_out_b), int'(enc[i].mlt));
    end

    // 1,0,0,1 from reset.
    do_reset();
    begin
      logic       s_din[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0] s_exp[4] = '{2'b01, 2'b01, 2'b01, 2'b00};
      for (int i = 0; i < 4; i++) begin
        data_in = s_din[i];
        step();
        check($sformatf("hold[%0d]", i), int'(mlt_out), int'(s_exp[i]));
      end
    end

    // Decoder table on an externally driven line, both CHECK_ORDER settings.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      line_drv = dtab[i].line;
      step();
      check($sformatf("dec_dout[%0d]", i), int'(data_out), int'(dtab[i].dout));
      check($sformatf("dec_err[%0d]", i), int'(error), int'(dtab[i].err));
      check($sformatf("decb_dout[%0d]", i), int'(data_out_b), int'(dtab[i].dout_b));
      check($sformatf("decb_err[%0d]", i), int'(error_b), int'(dtab[i].err_b));
    end

    // Loopback: data_out two edges after data_in is presented.
    do_reset();
    loop = 1'b1;
    for (int i = 0; i < 14; i++) begin
      data_in = lb_stream[i];
      step();
      if (i >= 1) begin
        check($sformatf("loop_dout[%0d]", i), int'(data_out), int'(lb_stream[i-1]));
        check($sformatf("loop_err[%0d]", i), int'(error), 0);
      end
    end

    // Mid-stream asynchronous reset while the line sits at -1.
    do_reset();
    loop = 1'b1;
    data_in = 1'b1;
    step();
    step();
    step();
    check("mid_pre_mlt", int'(mlt_out), 3);
    data_in = 1'b0;
    step();
    check("mid_pre_dout", int'(data_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_async_mlt", int'(mlt_out), 0);
    check("mid_async_dout", int'(data_out), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    data_in = 1'b1;
    step();
    check("mid_resume_mlt", int'(mlt_out), 1);
    check("mid_resume_err", int'(error), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
